// File: rtl/ft_recovery_ctrl_if.sv
// Checkpoint-memory read port: sequencer is master, checkpoint memory is slave.
interface ft_recovery_ctrl_if;
  logic        req_o;
  logic        gnt_i;
  logic [31:0] addr_o;
  logic        rvalid_i;
  logic [31:0] rdata_i;
  logic        err_i;

  modport master (
    output req_o, addr_o,
    input  gnt_i, rvalid_i, rdata_i, err_i
  );

  modport slave (
    input  req_o, addr_o,
    output gnt_i, rvalid_i, rdata_i, err_i
  );
endinterface

// File: rtl/ft_recovery_ctrl.sv
// Rollback sequencer: reads checkpointed x1..x(NUM_REGS-1) and the saved PC
// from checkpoint memory, replays registers into the core RF, then loads PC.
module ft_recovery_ctrl #(
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned PC_ADDR  = 32,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  ft_recovery_ctrl_if.master ckpt,
  output logic               busy_o,
  output logic               done_o,
  output logic               error_o,
  output logic               rf_we_o,
  output logic [4:0]         rf_waddr_o,
  output logic [31:0]        rf_wdata_o,
  output logic               pc_set_o,
  output logic [31:0]        pc_o
);

  localparam int unsigned MAX_IDX = (PC_ADDR > NUM_REGS) ? PC_ADDR : NUM_REGS;
  localparam int unsigned IDX_W   = $clog2(MAX_IDX + 1);
  localparam int unsigned TMO_W   = $clog2(TIMEOUT + 1);
  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned RF_AW   = 5;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_FINISH
  } state_e;

  state_e              state_q,    state_d;
  logic [IDX_W-1:0]    idx_q,      idx_d;
  logic [TMO_W-1:0]    tmo_q,      tmo_d;
  logic                busy_q,     busy_d;
  logic                done_q,     done_d;
  logic                error_q,    error_d;
  logic                rf_we_q,    rf_we_d;
  logic [RF_AW-1:0]    rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0]   rf_wdata_q, rf_wdata_d;
  logic                pc_set_q,   pc_set_d;
  logic [DATA_W-1:0]   pc_q,       pc_d;

  logic [IDX_W-1:0]    idx_inc;
  logic                tmo_hit;

  assign idx_inc = idx_q + IDX_W'(1);
  assign tmo_hit = (tmo_q == TMO_W'(TIMEOUT - 1));

  // Request and address are decoded from state so they drop with an async reset.
  assign ckpt.req_o  = (state_q == S_REQ);
  assign ckpt.addr_o = (state_q == S_REQ) ? ADDR_W'({idx_q, 2'b00}) : '0;

  // Next-state, index/timeout bookkeeping and registered output values.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    tmo_d      = tmo_q;
    done_d     = 1'b0;
    error_d    = 1'b0;
    rf_we_d    = 1'b0;
    pc_set_d   = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    pc_d       = pc_q;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_REQ;
          idx_d   = IDX_W'(1);
          tmo_d   = '0;
        end
      end

      S_REQ: begin
        if (ckpt.gnt_i) begin
          state_d = S_WAIT;
          tmo_d   = '0;
        end else if (tmo_hit) begin
          state_d = S_IDLE;
          error_d = 1'b1;
          tmo_d   = '0;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end

      S_WAIT: begin
        if (ckpt.rvalid_i) begin
          tmo_d = '0;
          if (ckpt.err_i) begin
            state_d = S_IDLE;
            error_d = 1'b1;
          end else if (idx_q == IDX_W'(PC_ADDR)) begin
            state_d  = S_FINISH;
            pc_d     = ckpt.rdata_i;
            pc_set_d = 1'b1;
            done_d   = 1'b1;
          end else begin
            state_d    = S_REQ;
            rf_we_d    = 1'b1;
            rf_waddr_d = RF_AW'(idx_q);
            rf_wdata_d = ckpt.rdata_i;
            idx_d      = (idx_inc == IDX_W'(NUM_REGS)) ? IDX_W'(PC_ADDR) : idx_inc;
          end
        end else if (tmo_hit) begin
          state_d = S_IDLE;
          error_d = 1'b1;
          tmo_d   = '0;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end

      S_FINISH: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d == S_REQ) || (state_d == S_WAIT);
  end

  // State and output registers; everything clears on reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      tmo_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      pc_set_q   <= 1'b0;
      pc_q       <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      tmo_q      <= tmo_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      pc_set_q   <= pc_set_d;
      pc_q       <= pc_d;
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign error_o    = error_q;
  assign rf_we_o    = rf_we_q;
  assign rf_waddr_o = rf_waddr_q;
  assign rf_wdata_o = rf_wdata_q;
  assign pc_set_o   = pc_set_q;
  assign pc_o       = pc_q;

endmodule
